// File: rtl/vector_pkg.sv
// Shared fixed-point types and helpers for the SDF responder.
// fp is signed Q8.24; every helper saturates instead of wrapping.
package vector_pkg;

  typedef logic signed [31:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  typedef enum logic [1:0] {
    SdfIdle   = 2'd0,
    SdfLoad   = 2'd1,
    SdfSqrt   = 2'd2,
    SdfFinish = 2'd3
  } sdf_state_t;

  localparam fp FP_MAX = 32'sh7FFFFFFF;
  localparam fp FP_MIN = 32'sh80000000;

  localparam int unsigned SDF_LATENCY = 35;
  localparam int unsigned SQRT_ITERS  = 32;

  function automatic fp fp_sat_add(fp a, fp b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? FP_MIN : FP_MAX;
    return fp'(s[31:0]);
  endfunction

  function automatic fp fp_sat_sub(fp a, fp b);
    logic [32:0] s;
    s = {a[31], a} - {b[31], b};
    if (s[32] != s[31]) return s[32] ? FP_MIN : FP_MAX;
    return fp'(s[31:0]);
  endfunction

  // |MIN| is not representable, so it pins to MAX.
  function automatic fp fp_abs_sat(fp a);
    if (a == FP_MIN) return FP_MAX;
    return a[31] ? -a : a;
  endfunction

  function automatic fp fp_max(fp a, fp b);
    return (a > b) ? a : b;
  endfunction

  function automatic fp fp_min(fp a, fp b);
    return (a < b) ? a : b;
  endfunction

  function automatic vec3 vec_sat_sub(vec3 a, vec3 b);
    vec3 r;
    r.x = fp_sat_sub(a.x, b.x);
    r.y = fp_sat_sub(a.y, b.y);
    r.z = fp_sat_sub(a.z, b.z);
    return r;
  endfunction

endpackage

// File: rtl/sdf_scene_responder_if.sv
// Distance-query handshake between a ray marcher (master) and the SDF responder (slave).
interface sdf_scene_responder_if;
  import vector_pkg::*;

  logic valid_in;
  vec3  pos;
  logic obj_sel;
  logic ready;
  fp    closestDistance;
  logic valid_out;

  modport master (
    output valid_in, pos, obj_sel,
    input  ready, closestDistance, valid_out
  );

  modport slave (
    input  valid_in, pos, obj_sel,
    output ready, closestDistance, valid_out
  );

endinterface

// File: rtl/fp_sqrt_seq.sv
// Bit-serial restoring integer square root: 64-bit radicand, 32-bit floor root,
// one root bit per cycle MSB first. done pulses once after SQRT_ITERS iterations.
module fp_sqrt_seq
  import vector_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] radicand,
  output logic [31:0] root,
  output logic        done
);

  logic [63:0] rad_q, rad_d;
  logic [35:0] rem_q, rem_d;
  logic [31:0] root_q, root_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [35:0] rem_sh;
  logic [35:0] trial;

  // One restoring step per cycle; remainder stays below 2^34 so 36 bits is ample.
  always_comb begin
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rem_sh = (rem_q << 2) | {34'd0, rad_q[63:62]};
    trial  = {2'b00, root_q, 2'b01};
    if (start) begin
      rad_d  = radicand;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rad_d = rad_q << 2;
      if (rem_sh >= trial) begin
        rem_d  = rem_sh - trial;
        root_d = {root_q[30:0], 1'b1};
      end else begin
        rem_d  = rem_sh;
        root_d = {root_q[30:0], 1'b0};
      end
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'(SQRT_ITERS - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Engine state; async reset clears any in-flight root.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign root = root_q;
  assign done = done_q;

endmodule

// File: rtl/sdf_scene_responder.sv
// Ray-march distance-query responder: signed distance to a sphere or a box,
// one shared sequential square root per query, 35-cycle latency.
// Optional ground plane enabled by defining SDF_GROUND_PLANE_EN.
module sdf_scene_responder
  import vector_pkg::*;
#(
  parameter vec3 SPHERE_C = '{x: 32'sh0, y: 32'sh0, z: 32'sh03000000},
  parameter fp   SPHERE_R = 32'sh01000000,
  parameter vec3 BOX_C    = '{x: 32'sh0, y: 32'sh0, z: 32'sh03000000},
  parameter fp   BOX_HALF = 32'sh00C00000
`ifdef SDF_GROUND_PLANE_EN
  ,
  parameter fp   PLANE_Y  = 32'shFF000000
`endif
) (
  input logic                  clk,
  input logic                  rst,
  sdf_scene_responder_if.slave bus
);

  localparam logic [1:0] StIdle   = SdfIdle;
  localparam logic [1:0] StLoad   = SdfLoad;
  localparam logic [1:0] StSqrt   = SdfSqrt;
  localparam logic [1:0] StFinish = SdfFinish;

  logic [1:0] state_q, state_d;
  vec3        pos_q, pos_d;
  logic       sel_q, sel_d;
  fp          m_q, m_d;
  fp          dist_q, dist_d;
  logic       vout_q, vout_d;

  vec3                sph_d, box_diff, box_q, box_d, dvec;
  fp                  box_qmax, box_m;
  logic signed [63:0] sq_x, sq_y, sq_z;
  logic [65:0]        rad_sum;
  logic [63:0]        radicand;
  logic [31:0]        sqrt_root;
  logic               sqrt_done;
  fp                  root_fp, obj_dist, result;

  // LOAD datapath: distance vector from captured pos, and its squared length.
  always_comb begin
    sph_d    = vec_sat_sub(pos_q, SPHERE_C);
    box_diff = vec_sat_sub(pos_q, BOX_C);
    box_q.x  = fp_sat_sub(fp_abs_sat(box_diff.x), BOX_HALF);
    box_q.y  = fp_sat_sub(fp_abs_sat(box_diff.y), BOX_HALF);
    box_q.z  = fp_sat_sub(fp_abs_sat(box_diff.z), BOX_HALF);
    box_qmax = fp_max(box_q.x, fp_max(box_q.y, box_q.z));
    box_m    = fp_min(box_qmax, '0);
    box_d.x  = fp_max(box_q.x, '0);
    box_d.y  = fp_max(box_q.y, '0);
    box_d.z  = fp_max(box_q.z, '0);
    dvec     = sel_q ? box_d : sph_d;
    sq_x     = dvec.x * dvec.x;
    sq_y     = dvec.y * dvec.y;
    sq_z     = dvec.z * dvec.z;
    rad_sum  = {2'b00, sq_x} + {2'b00, sq_y} + {2'b00, sq_z};
    radicand = (|rad_sum[65:64]) ? '1 : rad_sum[63:0];
  end

  fp_sqrt_seq u_sqrt (
    .clk      (clk),
    .rst      (rst),
    .start    (state_q == StLoad),
    .radicand (radicand),
    .root     (sqrt_root),
    .done     (sqrt_done)
  );

  // FINISH datapath: Q16.48 root is already Q8.24; roots >= 128.0 pin to MAX.
  always_comb begin
    root_fp  = sqrt_root[31] ? FP_MAX : fp'(sqrt_root);
    obj_dist = sel_q ? fp_sat_add(root_fp, m_q) : fp_sat_sub(root_fp, SPHERE_R);
`ifdef SDF_GROUND_PLANE_EN
    result   = fp_min(obj_dist, fp_sat_sub(pos_q.y, PLANE_Y));
`else
    result   = obj_dist;
`endif
  end

  // Query FSM: capture on accept, hand off to the sqrt engine, register the result.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    sel_d   = sel_q;
    m_d     = m_q;
    dist_d  = dist_q;
    vout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.valid_in) begin
          pos_d   = bus.pos;
          sel_d   = bus.obj_sel;
          state_d = StLoad;
        end
      end
      StLoad: begin
        m_d     = box_m;
        state_d = StSqrt;
      end
      StSqrt: begin
        if (sqrt_done) state_d = StFinish;
      end
      StFinish: begin
        dist_d  = result;
        vout_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and capture registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pos_q   <= '0;
      sel_q   <= 1'b0;
      m_q     <= '0;
      dist_q  <= '0;
      vout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      sel_q   <= sel_d;
      m_q     <= m_d;
      dist_q  <= dist_d;
      vout_q  <= vout_d;
    end
  end

  assign bus.ready           = (state_q == StIdle);
  assign bus.closestDistance = dist_q;
  assign bus.valid_out       = vout_q;

endmodule

// File: tb/tb_sdf_scene_responder.sv
// Scoreboard bench for sdf_scene_responder: expected distances are queued as
// each query is issued and popped when valid_out fires.
module tb_sdf_scene_responder;
  import vector_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdf_scene_responder_if bus ();

  sdf_scene_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  int acc_cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  fp  exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

`ifdef SDF_GROUND_PLANE_EN
  localparam fp EXP_SPH0 = 32'h01000000;
  localparam fp EXP_BOX0 = 32'h01000000;
  localparam fp EXP_BOXN = 32'h00000000;
`else
  localparam fp EXP_SPH0 = 32'h02000000;
  localparam fp EXP_BOX0 = 32'h02400000;
  localparam fp EXP_BOXN = 32'h005A8279;
`endif

  typedef struct {
    vec3  p;
    logic s;
    fp    e;
  } pt_t;

  function automatic vec3 mk(fp x, fp y, fp z);
    vec3 v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

  // Called just after a negedge; returns 1 ns after the accept edge.
  task automatic send(input vec3 p, input logic s);
    bus.valid_in = 1'b1;
    bus.pos      = p;
    bus.obj_sel  = s;
    @(posedge clk);
    #1;
    acc_cyc      = cyc;
    bus.valid_in = 1'b0;
    bus.pos      = mk(32'h07000000, 32'h07000000, 32'h07000000);
    bus.obj_sel  = ~s;
  endtask

  task automatic wait_out(output fp val, output int lat, output bit seen);
    seen = 1'b0;
    val  = '0;
    lat  = -1;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) begin
        seen = 1'b1;
        val  = bus.closestDistance;
        lat  = cyc - acc_cyc;
      end
    end
  endtask

  task automatic test_reset;
    rst          = 1'b0;
    bus.valid_in = 1'b0;
    bus.pos      = '0;
    bus.obj_sel  = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.ready !== 1'b1 || bus.valid_out !== 1'b0 || bus.closestDistance !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b valid_out=%b dist=%h, want 1 0 00000000",
               bus.ready, bus.valid_out, bus.closestDistance);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.ready !== 1'b1 || bus.valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_idle: ready=%b valid_out=%b, want 1 0", bus.ready, bus.valid_out);
    end
  endtask

  task automatic test_sphere_origin;
    fp got, exp;
    int lat;
    bit seen;
    @(negedge clk);
    exp_q.push_back(EXP_SPH0);
    send(mk(0, 0, 0), 1'b0);
    wait_out(got, lat, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!seen || got !== exp) begin
      miscompares++;
      $display("FAIL sphere_origin: seen=%0d got %h, want %h", seen, got, exp);
    end
    vectors++;
    if (lat != int'(SDF_LATENCY)) begin
      miscompares++;
      $display("FAIL sphere_latency: got %0d cycles, want %0d", lat, SDF_LATENCY);
    end
    @(negedge clk);
    vectors++;
    if (bus.valid_out !== 1'b0 || bus.closestDistance !== exp) begin
      miscompares++;
      $display("FAIL pulse_width_hold: valid_out=%b dist=%h, want 0 %h",
               bus.valid_out, bus.closestDistance, exp);
    end
  endtask

  task automatic test_points;
    pt_t pts[7];
    fp got, exp;
    int lat;
    bit seen;
    pts[0] = '{p: mk(0, 0, 32'h03000000), s: 1'b0, e: 32'hFF000000};
    pts[1] = '{p: mk(0, 0, 0), s: 1'b1, e: EXP_BOX0};
    pts[2] = '{p: mk(0, 0, 32'h03000000), s: 1'b1, e: 32'hFF400000};
    pts[3] = '{p: mk(32'h7F000000, 32'h7F000000, 32'h7F000000), s: 1'b0, e: 32'h7EFFFFFF};
    pts[4] = '{p: mk(32'h03000000, 32'h04000000, 32'h03000000), s: 1'b0, e: 32'h04000000};
    pts[5] = '{p: mk(32'h01000000, 0, 32'h03000000), s: 1'b1, e: 32'h00400000};
    pts[6] = '{p: mk(32'hFF000000, 32'hFF000000, 32'h03000000), s: 1'b1, e: EXP_BOXN};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      exp_q.push_back(pts[i].e);
      send(pts[i].p, pts[i].s);
      wait_out(got, lat, seen);
      exp = exp_q.pop_front();
      vectors++;
      if (!seen || got !== exp || lat != int'(SDF_LATENCY) || bus.ready !== 1'b1) begin
        miscompares++;
        $display("FAIL point_%0d: seen=%0d got %h lat %0d ready %b, want %h lat %0d ready 1",
                 i, seen, got, lat, bus.ready, exp, SDF_LATENCY);
      end
    end
  endtask

  task automatic test_ignore_mid_query;
    fp got, exp;
    int lat, extra;
    bit seen;
    @(negedge clk);
    exp_q.push_back(EXP_SPH0);
    send(mk(0, 0, 0), 1'b0);
    repeat (5) @(negedge clk);
    bus.valid_in = 1'b1;
    bus.pos      = mk(0, 0, 32'h03000000);
    bus.obj_sel  = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    wait_out(got, lat, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!seen || got !== exp || lat != int'(SDF_LATENCY)) begin
      miscompares++;
      $display("FAIL ignore_mid_query: seen=%0d got %h lat %0d, want %h lat %0d",
               seen, got, lat, exp, SDF_LATENCY);
    end
    extra = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL dropped_query_output: got %0d extra pulses, want 0", extra);
    end
  endtask

  task automatic test_back_to_back;
    fp got, exp;
    int lat;
    bit seen;
    @(negedge clk);
    exp_q.push_back(EXP_SPH0);
    exp_q.push_back(32'hFF400000);
    send(mk(0, 0, 0), 1'b0);
    wait_out(got, lat, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!seen || got !== exp || bus.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: seen=%0d got %h ready %b, want %h ready 1",
               seen, got, bus.ready, exp);
    end
    send(mk(0, 0, 32'h03000000), 1'b1);
    wait_out(got, lat, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!seen || got !== exp || lat != int'(SDF_LATENCY)) begin
      miscompares++;
      $display("FAIL b2b_second: seen=%0d got %h lat %0d, want %h lat %0d",
               seen, got, lat, exp, SDF_LATENCY);
    end
  endtask

  task automatic test_reset_mid_query;
    fp got, exp;
    int lat, extra;
    bit seen;
    @(negedge clk);
    send(mk(32'h7F000000, 32'h7F000000, 32'h7F000000), 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.ready !== 1'b1 || bus.valid_out !== 1'b0 || bus.closestDistance !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_query: ready=%b valid_out=%b dist=%h, want 1 0 00000000",
               bus.ready, bus.valid_out, bus.closestDistance);
    end
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.valid_out === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0 || bus.closestDistance !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_discard: got %0d pulses dist %h, want 0 pulses dist 00000000",
               extra, bus.closestDistance);
    end
    @(negedge clk);
    exp_q.push_back(32'h01000000);
    send(mk(0, 0, 32'h01000000), 1'b0);
    wait_out(got, lat, seen);
    exp = exp_q.pop_front();
    vectors++;
    if (!seen || got !== exp || lat != int'(SDF_LATENCY)) begin
      miscompares++;
      $display("FAIL after_reset_query: seen=%0d got %h lat %0d, want %h lat %0d",
               seen, got, lat, exp, SDF_LATENCY);
    end
  endtask

  initial begin
    test_reset();
    test_sphere_origin();
    test_points();
    test_ignore_mid_query();
    test_back_to_back();
    test_reset_mid_query();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
